addsub_share_arb: RTL and testbench

Round-robin arbiter and sequencer that time-shares one registered 8-bit unsigned adder/subtractor among NUM_REQ requesters. Each requester raises a request with its operands and operation. The block grants one requester at a time, captures its operands, performs the add or subtract, and returns the result tagged with the requester ID. It sits between the client blocks and the shared arithmetic resource.

---
 rtl/addsub_share_pkg.sv | 14 +
 rtl/addsub_share_arb_rr_pick.sv | 36 +++
 rtl/addsub_share_arb.sv | 127 ++++++++++++
 tb/tb_addsub_share_arb.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_share_pkg.sv
// Shared types for the time-shared add/subtract arbiter.
package addsub_share_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EXEC = 2'd2,
    RESP = 2'd3
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/addsub_share_arb_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr_i,
// wrapping to the lowest set request when none is found above the pointer.
module rr_pick
  import addsub_share_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDW-1:0]     ptr_i,
  output logic               any_req_o,
  output logic [IDW-1:0]     winner_o
);

  logic found;

  // First pass honours the pointer; the second pass supplies the wrap-around winner.
  always_comb begin
    any_req_o = |req_i;
    winner_o  = '0;
    found     = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_i[i] && (IDW'(i) >= ptr_i)) begin
        winner_o = IDW'(i);
        found    = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_i[i]) begin
        winner_o = IDW'(i);
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/addsub_share_arb.sv
// Round-robin sequencer sharing one registered add/subtract unit among NUM_REQ clients.
// Define ADDSUB_SHARE_SAT_EN for saturating results instead of modular wrap-around.
module addsub_share_arb
  import addsub_share_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         oper,
  input  logic [NUM_REQ*WIDTH-1:0]   a_in,
  input  logic [NUM_REQ*WIDTH-1:0]   b_in,
  output logic [NUM_REQ-1:0]         gnt,
  output logic                       res_valid,
  output logic [$clog2(NUM_REQ)-1:0] res_id,
  output logic [WIDTH-1:0]           res,
  output logic                       carry
);

  localparam int IDW = $clog2(NUM_REQ);

  state_e           state_q, state_d;
  logic [IDW-1:0]   winner_q, winner_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]   ptr_next, pick_ptr, pick_winner;
  logic             any_req;
  logic [WIDTH-1:0] opa_q, opb_q, res_q, res_d;
  logic             op_q, carry_q, carry_d;
  logic [WIDTH:0]   sum_ext;

  // In RESP the rotated pointer is used immediately so back-to-back grants stay fair.
  assign ptr_next = (winner_q == IDW'(NUM_REQ - 1)) ? '0 : winner_q + IDW'(1);
  assign pick_ptr = (state_q == RESP) ? ptr_next : rr_ptr_q;

  rr_pick #(
    .NUM_REQ(NUM_REQ),
    .IDW    (IDW)
  ) u_pick (
    .req_i    (req),
    .ptr_i    (pick_ptr),
    .any_req_o(any_req),
    .winner_o (pick_winner)
  );

  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          winner_d = pick_winner;
          state_d  = LOAD;
        end
      end
      LOAD: state_d = EXEC;
      EXEC: state_d = RESP;
      RESP: begin
        rr_ptr_d = ptr_next;
        if (any_req) begin
          winner_d = pick_winner;
          state_d  = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      winner_q <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // The borrow of the subtract lands in the extra MSB, so one bit serves as carry and borrow.
  always_comb begin
    if (op_q == OP_SUB) begin
      sum_ext = {1'b0, opa_q} - {1'b0, opb_q};
    end else begin
      sum_ext = {1'b0, opa_q} + {1'b0, opb_q};
    end
    carry_d = sum_ext[WIDTH];
    res_d   = sum_ext[WIDTH-1:0];
`ifdef ADDSUB_SHARE_SAT_EN
    if (carry_d) begin
      res_d = (op_q == OP_SUB) ? '0 : '1;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opa_q   <= '0;
      opb_q   <= '0;
      op_q    <= OP_ADD;
      res_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      if (state_q == LOAD) begin
        opa_q <= a_in[int'(winner_q) * WIDTH +: WIDTH];
        opb_q <= b_in[int'(winner_q) * WIDTH +: WIDTH];
        op_q  <= oper[winner_q];
      end
      if (state_q == EXEC) begin
        res_q   <= res_d;
        carry_q <= carry_d;
      end
    end
  end

  assign gnt       = (state_q == LOAD) ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << winner_q) : '0;
  assign res_valid = (state_q == RESP);
  assign res_id    = (state_q == RESP) ? winner_q : '0;
  assign res       = res_q;
  assign carry     = carry_q;

endmodule

// File: tb/tb_addsub_share_arb.sv
// Directed bench for addsub_share_arb: vector table plus contention, withdrawal,
// mid-transaction reset and pointer-wrap sequences; honours ADDSUB_SHARE_SAT_EN.
module tb_addsub_share_arb;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 8;
`ifdef ADDSUB_SHARE_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ-1:0]       oper;
  logic [NUM_REQ*WIDTH-1:0] aIn;
  logic [NUM_REQ*WIDTH-1:0] bIn;
  logic [NUM_REQ-1:0]       gnt;
  logic                     resValid;
  logic [1:0]               resId;
  logic [WIDTH-1:0]         res;
  logic                     carry;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int   id;
    logic op;
    int   a;
    int   b;
    int   expRes;
    int   expSat;
    logic expCarry;
  } vec_t;

  vec_t vecs[6];

  int   cA[4]     = '{1, 50, 128, 3};
  int   cB[4]     = '{2, 20, 128, 4};
  logic cOp[4]    = '{1'b0, 1'b1, 1'b0, 1'b1};
  int   cRes[4]   = '{3, 30, 0, 255};
  int   cSat[4]   = '{3, 30, 255, 0};
  logic cCarry[4] = '{1'b0, 1'b0, 1'b1, 1'b1};

  addsub_share_arb #(
    .NUM_REQ(NUM_REQ),
    .WIDTH  (WIDTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .oper     (oper),
    .a_in     (aIn),
    .b_in     (bIn),
    .gnt      (gnt),
    .res_valid(resValid),
    .res_id   (resId),
    .res      (res),
    .carry    (carry)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setRequester(input int id, input logic op, input int a, input int b);
    oper[id] = op;
    aIn[id*WIDTH +: WIDTH] = a[WIDTH-1:0];
    bIn[id*WIDTH +: WIDTH] = b[WIDTH-1:0];
    req[id] = 1'b1;
  endtask

  // Single transaction from IDLE: grant one cycle after sampling, result two cycles later.
  task automatic applyStimulus(input vec_t v);
    setRequester(v.id, v.op, v.a, v.b);
    tick();
    checkOutput("vec_gnt_load", 32'(gnt), 32'(1 << v.id));
    checkOutput("vec_valid_load", 32'(resValid), 0);
    tick();
    req[v.id] = 1'b0;
    checkOutput("vec_gnt_exec", 32'(gnt), 0);
    tick();
    checkOutput("vec_valid_resp", 32'(resValid), 1);
    checkOutput("vec_id", 32'(resId), v.id);
    checkOutput("vec_res", 32'(res), SAT ? v.expSat : v.expRes);
    checkOutput("vec_carry", 32'(carry), 32'(v.expCarry));
    tick();
    checkOutput("vec_valid_idle", 32'(resValid), 0);
    checkOutput("vec_gnt_idle", 32'(gnt), 0);
  endtask

  task automatic pulseReset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    vecs[0] = '{0, 1'b0, 200, 100,  44, 255, 1'b1};
    vecs[1] = '{2, 1'b1,   5,   9, 252,   0, 1'b1};
    vecs[2] = '{1, 1'b0,  10,  20,  30,  30, 1'b0};
    vecs[3] = '{3, 1'b1, 100,  40,  60,  60, 1'b0};
    vecs[4] = '{1, 1'b1,   7,   7,   0,   0, 1'b0};
    vecs[5] = '{3, 1'b0, 255,   1,   0, 255, 1'b1};

    reset = 1'b1;
    req   = '0;
    oper  = '0;
    aIn   = '0;
    bIn   = '0;
    tick();
    tick();
    checkOutput("rst_gnt", 32'(gnt), 0);
    checkOutput("rst_valid", 32'(resValid), 0);
    checkOutput("rst_id", 32'(resId), 0);
    checkOutput("rst_res", 32'(res), 0);
    checkOutput("rst_carry", 32'(carry), 0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i]);
    end

    // Contention: all four requesters hold their requests from a fresh reset.
    pulseReset();
    for (int i = 0; i < NUM_REQ; i++) begin
      setRequester(i, cOp[i], cA[i], cB[i]);
    end
    for (int cyc = 1; cyc <= 15; cyc++) begin
      tick();
      if (cyc % 3 == 1) begin
        checkOutput("cont_gnt", 32'(gnt), 32'(1 << ((cyc / 3) % 4)));
      end else begin
        checkOutput("cont_gnt_idle", 32'(gnt), 0);
      end
      if (cyc % 3 == 0) begin
        checkOutput("cont_valid", 32'(resValid), 1);
        checkOutput("cont_id", 32'(resId), (cyc / 3 - 1) % 4);
        checkOutput("cont_res", 32'(res), SAT ? cSat[(cyc / 3 - 1) % 4] : cRes[(cyc / 3 - 1) % 4]);
        checkOutput("cont_carry", 32'(carry), 32'(cCarry[(cyc / 3 - 1) % 4]));
      end else begin
        checkOutput("cont_valid_low", 32'(resValid), 0);
      end
    end
    req = '0;
    tick();
    tick();
    checkOutput("cont_drain_gnt", 32'(gnt), 0);

    // Withdrawal: req[1] pulses during requester 3's EXEC, requester 2 stays pending.
    setRequester(3, 1'b0, 40, 2);
    tick();
    checkOutput("wd_gnt3", 32'(gnt), 8);
    tick();
    req[3] = 1'b0;
    setRequester(1, 1'b0, 1, 1);
    setRequester(2, 1'b1, 9, 4);
    checkOutput("wd_gnt_exec", 32'(gnt), 0);
    tick();
    req[1] = 1'b0;
    checkOutput("wd_valid3", 32'(resValid), 1);
    checkOutput("wd_id3", 32'(resId), 3);
    checkOutput("wd_res3", 32'(res), 42);
    tick();
    checkOutput("wd_gnt2", 32'(gnt), 4);
    tick();
    req[2] = 1'b0;
    checkOutput("wd_gnt_exec2", 32'(gnt), 0);
    tick();
    checkOutput("wd_id2", 32'(resId), 2);
    checkOutput("wd_res2", 32'(res), 5);
    checkOutput("wd_carry2", 32'(carry), 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("wd_no_gnt", 32'(gnt), 0);
    end

    // Reset asserted in the middle of an EXEC cycle discards the operation.
    setRequester(0, 1'b0, 200, 100);
    tick();
    checkOutput("rx_gnt0", 32'(gnt), 1);
    tick();
    req[0] = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    checkOutput("rx_gnt", 32'(gnt), 0);
    checkOutput("rx_valid", 32'(resValid), 0);
    checkOutput("rx_res", 32'(res), 0);
    checkOutput("rx_carry", 32'(carry), 0);
    tick();
    checkOutput("rx_valid_held", 32'(resValid), 0);
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      checkOutput("rx_no_valid", 32'(resValid), 0);
    end
    setRequester(3, 1'b0, 9, 8);
    tick();
    checkOutput("rx_gnt3", 32'(gnt), 8);
    tick();
    req[3] = 1'b0;
    tick();
    checkOutput("rx_id3", 32'(resId), 3);
    checkOutput("rx_res3", 32'(res), 17);
    tick();

    // Pointer wrap: after serving requester 3, requester 0 wins over 3.
    setRequester(0, 1'b0, 15, 16);
    setRequester(3, 1'b1, 200, 55);
    tick();
    checkOutput("wrap_gnt0", 32'(gnt), 1);
    tick();
    req[0] = 1'b0;
    tick();
    checkOutput("wrap_id0", 32'(resId), 0);
    checkOutput("wrap_res0", 32'(res), 31);
    tick();
    checkOutput("wrap_gnt3", 32'(gnt), 8);
    tick();
    req[3] = 1'b0;
    tick();
    checkOutput("wrap_id3", 32'(resId), 3);
    checkOutput("wrap_res3", 32'(res), 145);
    checkOutput("wrap_carry3", 32'(carry), 0);
    tick();
    checkOutput("wrap_idle", 32'(gnt), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
